wb_queue: RTL and testbench

Write-back queue sitting directly upstream of the register file. It accepts up to two register results per cycle, one from the memory path and one from the ALU path, and buffers them in program order. It drains them one per cycle into the register file's single write port. Optionally it forwards the newest pending value for each of the two read sources, so decode never reads a stale register while writes are still queued.

---
 rtl/wb_queue.sv | 117 +++++++++++
 tb/tb_wb_queue.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/wb_queue.sv
// Write-back queue in front of the register file: takes up to two results per cycle
// (mem first, then alu), drains one per cycle. Forwarding lookup is built only when WBQ_FWD_EN is defined.
module wb_queue #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_valid,
  input  logic [ADDR_W-1:0] mem_dest,
  input  logic [DATA_W-1:0] mem_result,
  input  logic              alu_valid,
  input  logic [ADDR_W-1:0] alu_dest,
  input  logic [DATA_W-1:0] alu_result,
  output logic              stall,
  output logic [ADDR_W-1:0] Dest_wb,
  output logic [DATA_W-1:0] Result_WB,
  output logic              writeBackEn,
  input  logic [ADDR_W-1:0] src1,
  input  logic [ADDR_W-1:0] src2,
  output logic              fwd1_hit,
  output logic              fwd2_hit,
  output logic [DATA_W-1:0] fwd1_data,
  output logic [DATA_W-1:0] fwd2_data
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int unsigned STORE_LIMIT = 14;

  logic [ADDR_W-1:0] r_dest [DEPTH];
  logic [DATA_W-1:0] r_data [DEPTH];
  logic [PTR_W-1:0]  r_head;
  logic [PTR_W-1:0]  r_tail;
  logic [CNT_W-1:0]  r_count;

  logic              w_mem_acc;
  logic              w_alu_acc;
  logic              w_pop;
  logic [1:0]        w_push_cnt;
  logic [PTR_W-1:0]  w_alu_idx;

  // Handshake: a result is taken at a posedge when its valid is high and stall is low;
  // stall depends only on registered occupancy, so two pushes always fit.
  assign stall      = (r_count >= CNT_W'(DEPTH - 1));
  assign w_mem_acc  = mem_valid && !stall && (32'(mem_dest) < STORE_LIMIT);
  assign w_alu_acc  = alu_valid && !stall && (32'(alu_dest) < STORE_LIMIT);
  assign w_push_cnt = {1'b0, w_mem_acc} + {1'b0, w_alu_acc};
  assign w_pop      = (r_count != '0);
  assign w_alu_idx  = w_mem_acc ? r_tail + PTR_W'(1) : r_tail;

  always_ff @(posedge clk) begin
    if (!rst) begin
      if (w_mem_acc) begin
        r_dest[r_tail] <= mem_dest;
        r_data[r_tail] <= mem_result;
      end
      if (w_alu_acc) begin
        r_dest[w_alu_idx] <= alu_dest;
        r_data[w_alu_idx] <= alu_result;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_head      <= '0;
      r_tail      <= '0;
      r_count     <= '0;
      writeBackEn <= 1'b0;
      Dest_wb     <= '0;
      Result_WB   <= '0;
    end else begin
      r_tail  <= r_tail + PTR_W'(w_push_cnt);
      r_count <= r_count + CNT_W'(w_push_cnt) - CNT_W'(w_pop);
      if (w_pop) begin
        Dest_wb     <= r_dest[r_head];
        Result_WB   <= r_data[r_head];
        r_head      <= r_head + PTR_W'(1);
        writeBackEn <= 1'b1;
      end else begin
        writeBackEn <= 1'b0;
      end
    end
  end

`ifdef WBQ_FWD_EN
  // Scan oldest to newest so the last match wins; the entry already in Dest_wb has left the queue.
  always_comb begin
    fwd1_hit  = 1'b0;
    fwd2_hit  = 1'b0;
    fwd1_data = '0;
    fwd2_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (i < int'(r_count)) begin
        if (r_dest[r_head + PTR_W'(i)] == src1) begin
          fwd1_hit  = 1'b1;
          fwd1_data = r_data[r_head + PTR_W'(i)];
        end
        if (r_dest[r_head + PTR_W'(i)] == src2) begin
          fwd2_hit  = 1'b1;
          fwd2_data = r_data[r_head + PTR_W'(i)];
        end
      end
    end
  end
`else
  logic w_unused_src;
  assign w_unused_src = ^{src1, src2};
  assign fwd1_hit  = 1'b0;
  assign fwd2_hit  = 1'b0;
  assign fwd1_data = '0;
  assign fwd2_data = '0;
`endif

endmodule

// File: tb/tb_wb_queue.sv
// Bench for wb_queue: queue-based reference model checked every cycle, directed scenarios
// with literal expectations, then randomized traffic with occasional resets.
module tb_wb_queue;
  localparam int DEPTH  = 4;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 4;
  localparam int W      = ADDR_W + DATA_W;

  logic              clk = 1'b0;
  logic              rst;
  logic              mem_valid, alu_valid;
  logic [ADDR_W-1:0] mem_dest, alu_dest, src1, src2;
  logic [DATA_W-1:0] mem_result, alu_result;
  logic              stall, writeBackEn, fwd1_hit, fwd2_hit;
  logic [ADDR_W-1:0] Dest_wb;
  logic [DATA_W-1:0] Result_WB, fwd1_data, fwd2_data;

  int n_tests = 0;
  int n_fail  = 0;
  int proto_cnt = 0;

  wb_queue #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst),
    .mem_valid(mem_valid), .mem_dest(mem_dest), .mem_result(mem_result),
    .alu_valid(alu_valid), .alu_dest(alu_dest), .alu_result(alu_result),
    .stall(stall), .Dest_wb(Dest_wb), .Result_WB(Result_WB), .writeBackEn(writeBackEn),
    .src1(src1), .src2(src2),
    .fwd1_hit(fwd1_hit), .fwd2_hit(fwd2_hit), .fwd1_data(fwd1_data), .fwd2_data(fwd2_data)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // reference model: pending writes in program order
  logic [W-1:0]      exp_q[$];
  logic              m_wbe  = 1'b0;
  logic [ADDR_W-1:0] m_dest = '0;
  logic [DATA_W-1:0] m_data = '0;

  function automatic void model_fwd(input logic [ADDR_W-1:0] src, output logic hit,
                                    output logic [DATA_W-1:0] data);
    logic [W-1:0] e;
    hit  = 1'b0;
    data = '0;
`ifdef WBQ_FWD_EN
    foreach (exp_q[i]) begin
      e = exp_q[i];
      if (e[W-1:DATA_W] == src) begin
        hit  = 1'b1;
        data = e[DATA_W-1:0];
      end
    end
`else
    e = '0;
`endif
  endfunction

  always @(posedge clk) begin
    logic [W-1:0]      e;
    logic              pre_stall;
    logic              h1, h2;
    logic [DATA_W-1:0] d1, d2;
    if (rst) begin
      exp_q.delete();
      m_wbe  = 1'b0;
      m_dest = '0;
      m_data = '0;
    end else begin
      pre_stall = (exp_q.size() >= DEPTH - 1);
      if (exp_q.size() > 0) begin
        e      = exp_q.pop_front();
        m_wbe  = 1'b1;
        m_dest = e[W-1:DATA_W];
        m_data = e[DATA_W-1:0];
      end else begin
        m_wbe = 1'b0;
      end
      if (pre_stall) begin
        if (mem_valid || alu_valid) proto_cnt++;
      end else begin
        if (mem_valid && mem_dest < 14) exp_q.push_back({mem_dest, mem_result});
        if (alu_valid && alu_dest < 14) exp_q.push_back({alu_dest, alu_result});
      end
    end
    #1;
    model_fwd(src1, h1, d1);
    model_fwd(src2, h2, d2);
    chk("stall",       64'(stall),       64'(exp_q.size() >= DEPTH - 1));
    chk("writeBackEn", 64'(writeBackEn), 64'(m_wbe));
    chk("Dest_wb",     64'(Dest_wb),     64'(m_dest));
    chk("Result_WB",   64'(Result_WB),   64'(m_data));
    chk("fwd1_hit",    64'(fwd1_hit),    64'(h1));
    chk("fwd1_data",   64'(fwd1_data),   64'(d1));
    chk("fwd2_hit",    64'(fwd2_hit),    64'(h2));
    chk("fwd2_data",   64'(fwd2_data),   64'(d2));
  end

  // driver tasks
  task automatic idle();
    mem_valid = 1'b0;
    alu_valid = 1'b0;
  endtask

  task automatic push(input logic mv, input logic [ADDR_W-1:0] md, input logic [DATA_W-1:0] mr,
                      input logic av, input logic [ADDR_W-1:0] ad, input logic [DATA_W-1:0] ar);
    mem_valid = mv; mem_dest = md; mem_result = mr;
    alu_valid = av; alu_dest = ad; alu_result = ar;
  endtask

  initial begin
    rst = 1'b1;
    mem_valid = 1'b0; mem_dest = '0; mem_result = '0;
    alu_valid = 1'b0; alu_dest = '0; alu_result = '0;
    src1 = '0; src2 = '0;

    @(negedge clk);
    chk("rst_wbe",   64'(writeBackEn), 64'd0);
    chk("rst_dest",  64'(Dest_wb),     64'd0);
    chk("rst_res",   64'(Result_WB),   64'd0);
    chk("rst_stall", 64'(stall),       64'd0);
    rst = 1'b0;
    @(negedge clk);

    // single push
    src1 = 4'd3;
    push(1'b1, 4'd3, 32'hDEADBEEF, 1'b0, 4'd0, 32'h0);
    @(negedge clk); idle();
`ifdef WBQ_FWD_EN
    chk("single_fwd", 64'(fwd1_data), 64'hDEADBEEF);
`endif
    @(negedge clk);
    chk("single_wbe",  64'(writeBackEn), 64'd1);
    chk("single_dest", 64'(Dest_wb),     64'd3);
    chk("single_res",  64'(Result_WB),   64'hDEADBEEF);
    @(negedge clk);
    chk("single_wbe_off", 64'(writeBackEn), 64'd0);

    // dual push, same dest: program order mem then alu
    src1 = 4'd2;
    push(1'b1, 4'd2, 32'h11, 1'b1, 4'd2, 32'h22);
    @(negedge clk); idle();
`ifdef WBQ_FWD_EN
    chk("dual_fwd_hit",  64'(fwd1_hit),  64'd1);
    chk("dual_fwd_data", 64'(fwd1_data), 64'h22);
`endif
    @(negedge clk);
    chk("dual_first",  64'(Result_WB), 64'h11);
    @(negedge clk);
    chk("dual_second", 64'(Result_WB), 64'h22);
    @(negedge clk);

    // fill to stall, one ignored offer, then drain
    push(1'b1, 4'd1, 32'hA1, 1'b1, 4'd4, 32'hA2);
    @(negedge clk);
    chk("fill_stall0", 64'(stall), 64'd0);
    push(1'b1, 4'd5, 32'hA3, 1'b1, 4'd6, 32'hA4);
    @(negedge clk);
    chk("fill_stall1", 64'(stall), 64'd1);
    push(1'b1, 4'd7, 32'hBAD, 1'b0, 4'd0, 32'h0);
    @(negedge clk); idle();
    chk("fill_stall_fall", 64'(stall),     64'd0);
    chk("fill_w2",         64'(Result_WB), 64'hA2);
    @(negedge clk);
    chk("fill_w3", 64'(Result_WB), 64'hA3);
    @(negedge clk);
    chk("fill_w4", 64'(Result_WB), 64'hA4);
    @(negedge clk);
    chk("fill_no_extra", 64'(writeBackEn), 64'd0);

    // wrap: 10 single pushes interleaved with drains
    for (int i = 0; i < 10; i++) begin
      push(1'b1, ADDR_W'(i % 14), 32'h100 + 32'(i), 1'b0, 4'd0, 32'h0);
      @(negedge clk); idle();
      @(negedge clk);
      chk("wrap_res", 64'(Result_WB), 64'h100 + 64'(i));
    end
    @(negedge clk);

    // dropped destination
    src1 = 4'd15; src2 = 4'd15;
    push(1'b0, 4'd0, 32'h0, 1'b1, 4'd15, 32'h55);
    @(negedge clk); idle();
    chk("drop_hit", 64'(fwd1_hit), 64'd0);
    @(negedge clk);
    chk("drop_wbe", 64'(writeBackEn), 64'd0);

    // reset with entries pending
    push(1'b1, 4'd1, 32'h1, 1'b1, 4'd2, 32'h2);
    @(negedge clk);
    push(1'b1, 4'd3, 32'h3, 1'b1, 4'd4, 32'hABCD);
    @(negedge clk); idle();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_wbe",   64'(writeBackEn), 64'd0);
    chk("midrst_stall", 64'(stall),       64'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("midrst_no_write", 64'(writeBackEn), 64'd0);
    end

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      logic ok;
      @(negedge clk);
      ok         = (exp_q.size() < DEPTH - 1) || ($urandom_range(0, 31) == 0);
      mem_valid  = ok && ($urandom_range(0, 2) != 0);
      alu_valid  = ok && ($urandom_range(0, 2) != 0);
      mem_dest   = ADDR_W'($urandom_range(0, 15));
      alu_dest   = ADDR_W'($urandom_range(0, 15));
      mem_result = $urandom;
      alu_result = $urandom;
      src1       = ADDR_W'($urandom_range(0, 15));
      src2       = ADDR_W'($urandom_range(0, 15));
      rst        = ($urandom_range(0, 199) == 0);
    end
    @(negedge clk);
    idle();
    rst = 1'b0;
    @(negedge clk);

    $display("[TB] protocol errors flagged (valid during stall, ignored): %0d", proto_cnt);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
